// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - command FIFO and settle/capture sequencer for the 4-bit ALU mux
//
// Queues {select, z} commands, issues one at a time to the combinational ALU mux,
// holds the mux inputs for SETTLE_CYCLES cycles, captures the mux result and offers
// it downstream on a valid/ready handshake.
//
// Parameters:
//   DEPTH          command FIFO depth (power of two, >= 2)
//   SETTLE_CYCLES  cycles the mux inputs are held before capture (1..15)
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_data  command push handshake, data = {select[1:0], z[10:0]}
//   flush                         clears queued commands; in-flight command unaffected
//   mux_z, mux_select, mux_out    drive to / result from the ALU mux
//   res_valid/res_ready/res_data  captured result handshake
//   busy                          sequencer active or commands queued
//   fifo_count                    FIFO occupancy, 0..DEPTH
//   done_count                    (ALU_SEQ_COUNT_EN only) 8-bit wrapping handshake count
//
// Optional feature macro: ALU_SEQ_COUNT_EN
module alu_sequencer #(
  parameter int DEPTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [12:0]              cmd_data,
  input  logic                     flush,
  output logic [10:0]              mux_z,
  output logic [1:0]               mux_select,
  input  logic [8:0]               mux_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [8:0]               res_data,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
`ifdef ALU_SEQ_COUNT_EN
  ,
  output logic [7:0]               done_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

  state_t          state, state_nx;
  logic [12:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [3:0]      settle_cnt;
  logic            full, empty, push, pop;

  assign full      = (fifo_count == FULL_CNT);
  assign empty     = (fifo_count == '0);
  assign cmd_ready = !full && !flush;
  assign push      = cmd_valid && cmd_ready;
  // flush takes priority over an IDLE pop so a flushed command never issues
  assign pop       = (state == IDLE) && !empty && !flush;
  assign busy      = (state != IDLE) || !empty;

  // command storage; no reset needed, occupancy is tracked by fifo_count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (flush) begin
      rd_ptr     <= wr_ptr;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pop) state_nx = SETTLE;
      // counter was loaded with SETTLE_CYCLES, so leaving at 1 gives exactly that many cycles
      SETTLE:  if (settle_cnt == 4'd1) state_nx = CAPTURE;
      CAPTURE: state_nx = HOLD;
      HOLD:    if (res_valid && res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mux_z      <= '0;
      mux_select <= 2'b11;
      res_valid  <= 1'b0;
      res_data   <= '0;
      settle_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            {mux_select, mux_z} <= mem[rd_ptr];
            settle_cnt          <= 4'(SETTLE_CYCLES);
          end
        end
        SETTLE:  settle_cnt <= settle_cnt - 4'd1;
        CAPTURE: begin
          res_data  <= mux_out;
          res_valid <= 1'b1;
        end
        HOLD:    if (res_ready) res_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)                       done_count <= '0;
    else if (res_valid && res_ready) done_count <= done_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - randomized, model-checked bench for alu_sequencer
module tb_alu_sequencer;

  localparam int DEPTH = 4;
  localparam int S     = 1;
  localparam int S4    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT, default parameters
  logic        reset, cmd_valid, cmd_ready, flush, res_valid, res_ready, busy;
  logic [12:0] cmd_data;
  logic [10:0] mux_z;
  logic [1:0]  mux_select;
  logic [8:0]  mux_out, res_data;
  logic [2:0]  fifo_count;
  // second DUT, SETTLE_CYCLES = 4
  logic        b_reset, b_cmd_valid, b_cmd_ready, b_flush, b_res_valid, b_res_ready, b_busy;
  logic [12:0] b_cmd_data;
  logic [10:0] b_mux_z;
  logic [1:0]  b_mux_select;
  logic [8:0]  b_mux_out, b_res_data;
  logic [2:0]  b_fifo_count;
`ifdef ALU_SEQ_COUNT_EN
  logic [7:0]  done_count, b_done_count;
`endif

  // behavioural ALU mux: logical / arithmetic / comparison units, select 3 gives 0
  function automatic logic [8:0] alu_ref(input logic [1:0] sel, input logic [10:0] z);
    logic [3:0] a, b;
    logic [1:0] op;
    logic       mode;
    logic [8:0] r;
    mode = z[10]; op = z[9:8]; a = z[7:4]; b = z[3:0];
    r = '0;
    case (sel)
      2'b00: begin
        case (op)
          2'd0:    r = {5'b0, a & b};
          2'd1:    r = {5'b0, a | b};
          2'd2:    r = {5'b0, a ^ b};
          default: r = {5'b0, ~a};
        endcase
        if (mode) r[3:0] = ~r[3:0];
      end
      2'b01: begin
        case (op)
          2'd0:    r = 9'(a) + 9'(b);
          2'd1:    r = 9'(a) - 9'(b);
          2'd2:    r = 9'(a) * 9'(b);
          default: r = 9'(a) + 9'(b) + 9'(mode);
        endcase
      end
      2'b10:   r = {6'b0, a > b, a == b, a < b};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign mux_out   = alu_ref(mux_select, mux_z);
  assign b_mux_out = alu_ref(b_mux_select, b_mux_z);

  alu_sequencer #(.DEPTH(DEPTH), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .flush(flush), .mux_z(mux_z), .mux_select(mux_select),
    .mux_out(mux_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .busy(busy), .fifo_count(fifo_count)
`ifdef ALU_SEQ_COUNT_EN
    , .done_count(done_count)
`endif
  );

  alu_sequencer #(.DEPTH(DEPTH), .SETTLE_CYCLES(S4)) dut4 (
    .clk(clk), .reset(b_reset), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_data(b_cmd_data), .flush(b_flush), .mux_z(b_mux_z), .mux_select(b_mux_select),
    .mux_out(b_mux_out), .res_valid(b_res_valid), .res_ready(b_res_ready),
    .res_data(b_res_data), .busy(b_busy), .fifo_count(b_fifo_count)
`ifdef ALU_SEQ_COUNT_EN
    , .done_count(b_done_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // transaction-level reference for the main DUT
  logic [12:0] mq[$];
  bit          m_busy, m_rv;
  int          m_wait;
  logic [8:0]  m_rd;
  logic [1:0]  m_sel;
  logic [10:0] m_z;
  logic [7:0]  m_dc;
  int          hs_seen;

  task automatic model_edge();
    bit hs, do_pop, do_push;
    logic [12:0] c;
    if (reset) begin
      mq.delete();
      m_busy = 0; m_rv = 0; m_wait = 0;
      m_rd = '0; m_sel = 2'b11; m_z = '0; m_dc = '0;
      return;
    end
    hs      = m_rv && res_ready;
    do_push = cmd_valid && !flush && (mq.size() < DEPTH);
    do_pop  = !m_busy && (mq.size() != 0) && !flush;
    if (m_busy) begin
      if (m_rv) begin
        if (hs) begin m_rv = 0; m_busy = 0; m_dc = m_dc + 8'd1; end
      end else begin
        // result appears S+1 edges after the pop
        m_wait--;
        if (m_wait == 0) begin m_rv = 1; m_rd = alu_ref(m_sel, m_z); end
      end
    end
    if (do_pop) begin
      c = mq.pop_front();
      m_sel = c[12:11]; m_z = c[10:0];
      m_busy = 1; m_wait = S + 1;
    end
    if (flush)   mq.delete();
    if (do_push) mq.push_back(cmd_data);
  endtask

  task automatic compare_all();
    check("cmd_ready",  32'(cmd_ready),  32'((mq.size() < DEPTH) && !flush));
    check("fifo_count", 32'(fifo_count), 32'(mq.size()));
    check("res_valid",  32'(res_valid),  32'(m_rv));
    check("res_data",   32'(res_data),   32'(m_rd));
    check("busy",       32'(busy),       32'(m_busy || mq.size() != 0));
    check("mux_select", 32'(mux_select), 32'(m_sel));
    check("mux_z",      32'(mux_z),      32'(m_z));
`ifdef ALU_SEQ_COUNT_EN
    check("done_count", 32'(done_count), 32'(m_dc));
`endif
  endtask

  task automatic step();
    if (!reset && res_valid && res_ready) hs_seen++;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1; cmd_valid = 0; flush = 0;
    step(); step();
    reset = 0;
  endtask

  task automatic push_cmd(input logic [12:0] d);
    int n;
    bit acc;
    cmd_valid = 1; cmd_data = d; n = 0;
    acc = 0;
    while (!acc && n < 50) begin
      acc = !flush && (mq.size() < DEPTH);
      step();
      n++;
    end
    check("push_accepted", 32'(acc), 32'd1);
    cmd_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    res_ready = 1;
    while ((m_busy || mq.size() != 0) && n < 200) begin step(); n++; end
    check("drain_done", 32'(m_busy || mq.size() != 0), 32'd0);
  endtask

  initial begin
    int n;
    reset = 1; cmd_valid = 0; cmd_data = '0; flush = 0; res_ready = 0;
    b_reset = 1; b_cmd_valid = 0; b_cmd_data = '0; b_flush = 0; b_res_ready = 1;
    hs_seen = 0;

    // reset values
    do_reset();
    check("rst_mux_select", 32'(mux_select), 32'd3);
    check("rst_mux_z",      32'(mux_z),      32'd0);
    check("rst_res_valid",  32'(res_valid),  32'd0);
    check("rst_cmd_ready",  32'(cmd_ready),  32'd1);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_busy",       32'(busy),       32'd0);

    // single command, A=3 B=5 add
    res_ready = 1;
    cmd_valid = 1; cmd_data = {2'b01, 11'b0_00_0011_0101};
    step();
    cmd_valid = 0;
    n = 0;
    while (!res_valid && n < 20) begin step(); n++; end
    check("latency",      32'(n),        32'd3);
    check("single_data",  32'(res_data), 32'd8);
    step();
    check("single_busy",  32'(busy),      32'd0);
    check("single_valid", 32'(res_valid), 32'd0);

    // backpressure: 5 commands with res_ready low
    do_reset();
    res_ready = 0;
    for (int i = 0; i < 5; i++) push_cmd(13'($urandom));
    check("bp_fifo_full", 32'(fifo_count), 32'(DEPTH));
    check("bp_cmd_ready", 32'(cmd_ready),  32'd0);
    check("bp_in_hold",   32'(res_valid),  32'd1);
    hs_seen = 0;
    drain();
    check("bp_results", 32'(hs_seen), 32'd5);

    // flush while holding a result
    do_reset();
    res_ready = 0;
    for (int i = 0; i < 4; i++) push_cmd(13'($urandom));
    n = 0;
    while (!res_valid && n < 20) begin step(); n++; end
    check("fl_queued", 32'(fifo_count), 32'd3);
    flush = 1; cmd_valid = 1; cmd_data = 13'($urandom);
    step();
    flush = 0; cmd_valid = 0;
    check("fl_count", 32'(fifo_count), 32'd0);
    hs_seen = 0;
    drain();
    check("fl_results", 32'(hs_seen), 32'd1);

    // randomized traffic with occasional flush and reset
    do_reset();
    for (int i = 0; i < 800; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_data  = 13'($urandom);
      res_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 0; flush = 0; cmd_valid = 0;
    drain();

`ifdef ALU_SEQ_COUNT_EN
    // 257 handshakes wrap the counter to 1
    do_reset();
    hs_seen = 0; res_ready = 1; n = 0;
    while (hs_seen < 257 && n < 5000) begin
      cmd_valid = 1; cmd_data = 13'($urandom);
      step();
      n++;
    end
    cmd_valid = 0;
    check("count_hs",   32'(hs_seen),    32'd257);
    check("count_wrap", 32'(done_count), 32'd1);
`endif

    // reset in the second SETTLE cycle of a SETTLE_CYCLES=4 instance
    res_ready = 1; cmd_valid = 0;
    b_reset = 0;
    b_cmd_valid = 1; b_cmd_data = {2'b10, 11'b0_00_0111_0010};
    step();
    b_cmd_valid = 0;
    step();
    check("b_pop_sel",   32'(b_mux_select), 32'd2);
    check("b_pop_z",     32'(b_mux_z),      32'h072);
    check("b_pop_busy",  32'(b_busy),       32'd1);
    step();
    b_reset = 1;
    step();
    b_reset = 0;
    check("b_rst_sel",   32'(b_mux_select), 32'd3);
    check("b_rst_z",     32'(b_mux_z),      32'd0);
    check("b_rst_valid", 32'(b_res_valid),  32'd0);
    check("b_rst_data",  32'(b_res_data),   32'd0);
    check("b_rst_busy",  32'(b_busy),       32'd0);
    check("b_rst_count", 32'(b_fifo_count), 32'd0);
    check("b_rst_ready", 32'(b_cmd_ready),  32'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      check("b_no_result", 32'(b_res_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
